bit_serial_alu: RTL and testbench

Multi-cycle, bit-serial integer ALU that processes one operand bit per clock, LSB first, through a single one-bit ALU slice plus a carry flip-flop. It sits between the operand/op issue logic and the register write-back path and trades latency for area. It accepts a start pulse, runs WIDTH bit-steps plus one fix-up cycle for set-less-than, then presents a registered result and flags with a one-cycle done pulse.

---
 rtl/bit_serial_alu_if.sv | 26 ++
 rtl/bit_serial_alu.sv | 164 ++++++++++++++++
 tb/tb_bit_serial_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bit_serial_alu_if.sv
// Issue/write-back bundle for the bit-serial ALU: operands and op go in,
// result and flags come back with a busy level and a one-cycle done pulse.
interface bit_serial_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, op, a, b,
      input  busy, done, result, zero, carry_out, overflow
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, zero, carry_out, overflow
   );
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial integer ALU: one operand bit per clock, LSB first, through a single
// one-bit slice and carry flop, plus a fix-up cycle that resolves set-less-than.
module bit_serial_alu #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   bit_serial_alu_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_busy;
   logic             w_done;
   logic             w_msb_step;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic             r_carry;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_acc;
   logic             r_msb_sum;
   logic             r_c_in_msb;
   logic             r_c_out_msb;

   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_carry_out;
   logic             r_overflow;

   logic             w_a0;
   logic             w_bv;
   logic             w_sum;
   logic             w_cnext;
   logic             w_slice;
   logic [WIDTH-1:0] w_fix_result;

   assign w_msb_step = (r_count == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (w_msb_step) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            w_busy       = 1'b1;
            w_state_next = S_DONE;
         end
         S_DONE: begin
            // A start here overlaps the done pulse so back-to-back ops lose no cycle.
            w_done = 1'b1;
            if (bus.start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // One-bit ALU slice on the current operand LSBs.
   always_comb begin
      w_a0    = r_a[0];
      w_bv    = r_b[0] ^ r_op[2];
      w_sum   = w_a0 ^ w_bv ^ r_carry;
      w_cnext = (w_a0 & w_bv) | (w_a0 & r_carry) | (w_bv & r_carry);
      case (r_op[1:0])
         2'b00:   w_slice = w_a0 & w_bv;
         2'b01:   w_slice = w_a0 | w_bv;
         2'b10:   w_slice = w_sum;
         default: w_slice = 1'b0;
      endcase
   end

   // Signed less-than is the MSB of a-b corrected by the overflow term.
   always_comb begin
      w_fix_result = r_acc;
      if (r_op[1:0] == 2'b11) begin
         w_fix_result = {{(WIDTH-1){1'b0}}, r_msb_sum ^ r_c_in_msb ^ r_c_out_msb};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_carry     <= 1'b0;
         r_count     <= '0;
         r_acc       <= '0;
         r_msb_sum   <= 1'b0;
         r_c_in_msb  <= 1'b0;
         r_c_out_msb <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_op    <= bus.op;
         r_carry <= bus.op[2];
         r_count <= '0;
         r_acc   <= '0;
      end else if (r_state == S_RUN) begin
         r_acc   <= {w_slice, r_acc[WIDTH-1:1]};
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_cnext;
         if (w_msb_step) begin
            r_msb_sum   <= w_sum;
            r_c_in_msb  <= r_carry;
            r_c_out_msb <= w_cnext;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end else if (r_state == S_FIX) begin
         r_result    <= w_fix_result;
         r_zero      <= (w_fix_result == '0);
         r_carry_out <= r_op[1] & r_c_out_msb;
         r_overflow  <= r_op[1] & (r_c_in_msb ^ r_c_out_msb);
      end
   end

   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.carry_out = r_carry_out;
   assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed-vector bench for bit_serial_alu at WIDTH = 8 with hand-computed results.
module tb_bit_serial_alu;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   bit_serial_alu_if #(.WIDTH(W)) bus ();

   bit_serial_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one op, wait for done (bounded), check latency, result, flags and hold.
   // poke >= 0 pulses a conflicting start at that RUN cycle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ez,
                         input logic ec, input logic ev, input int poke);
      logic [7:0] held;
      logic       stable;
      int         cyc;
      held = bus.result;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
      check_value({tag, "_busy"}, 32'(bus.busy), 32'd1);
      cyc    = 0;
      stable = 1'b1;
      while (!bus.done && cyc < 30) begin
         if (bus.result !== held) stable = 1'b0;
         if (cyc == poke) begin
            bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'hFF; bus.b = 8'hFF;
         end else begin
            bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      check_value({tag, "_lat"},    32'(cyc),           32'd9);
      check_value({tag, "_hold"},   32'(stable),        32'd1);
      check_value({tag, "_result"}, 32'(bus.result),    32'(er));
      check_value({tag, "_zero"},   32'(bus.zero),      32'(ez));
      check_value({tag, "_carry"},  32'(bus.carry_out), 32'(ec));
      check_value({tag, "_ovf"},    32'(bus.overflow),  32'(ev));
      check_value({tag, "_idle"},   32'(bus.busy),      32'd0);
      $display("%s op=%b a=%02h b=%02h -> result=%02h z=%b c=%b v=%b lat=%0d",
               tag, op, a, b, bus.result, bus.zero, bus.carry_out, bus.overflow, cyc);
      @(negedge clk);
      check_value({tag, "_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      int  t[$];
      bit  seen_done;

      reset = 1'b1;
      bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      check_value("rst_busy",   32'(bus.busy),      32'd0);
      check_value("rst_done",   32'(bus.done),      32'd0);
      check_value("rst_result", 32'(bus.result),    32'd0);
      check_value("rst_flags",  32'({bus.zero, bus.carry_out, bus.overflow}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("add",    3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, -1);
      run_op("sub",    3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, -1);
      run_op("slt_lt", 3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1, -1);
      run_op("slt_ge", 3'b111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, -1);
      run_op("and",    3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, -1);
      run_op("or",     3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, -1);
      run_op("andn",   3'b100, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0, -1);
      run_op("orn",    3'b101, 8'hF0, 8'h3C, 8'hF3, 1'b0, 1'b0, 1'b0, -1);
      run_op("poke",   3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 3);

      // Result holds while idle.
      repeat (5) @(negedge clk);
      check_value("idle_hold", 32'(bus.result), 32'h30);

      // Reset mid-RUN: immediate clear, no done pulse afterwards.
      run_op("pre_rst", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, -1);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h11; bus.b = 8'h22;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check_value("midrst_busy",   32'(bus.busy),     32'd0);
      check_value("midrst_result", 32'(bus.result),   32'd0);
      check_value("midrst_ovf",    32'(bus.overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      check_value("midrst_nodone", 32'(seen_done), 32'd0);
      $display("midrst busy=%b result=%02h done_seen=%b", bus.busy, bus.result, seen_done);

      // Start held high: one op every WIDTH+2 cycles.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h01; bus.b = 8'h02;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) t.push_back(i);
      end
      bus.start = 1'b0;
      check_value("b2b_count", 32'(t.size() >= 3), 32'd1);
      check_value("b2b_gap1",  32'((t.size() >= 3) ? t[1] - t[0] : 0), 32'd10);
      check_value("b2b_gap2",  32'((t.size() >= 3) ? t[2] - t[1] : 0), 32'd10);
      check_value("b2b_result", 32'(bus.result), 32'h03);
      $display("b2b done_pulses=%0d result=%02h", t.size(), bus.result);
      repeat (12) @(negedge clk);
      check_value("b2b_hold", 32'(bus.result), 32'h03);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
